// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core data-side blocks.
//
// Contents:
//   XLEN                      architectural register / data width
//   RESULT_SRC_MEM            ResultSrc code selecting load data in writeback
//   ARB_S_IDLE/WAIT/FORCE     state encodings of the data memory arbiter FSM
//   arb_cnt_width()           width needed to count 0..max_wait inclusive
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    localparam logic [1:0] ARB_S_IDLE  = 2'd0;
    localparam logic [1:0] ARB_S_WAIT  = 2'd1;
    localparam logic [1:0] ARB_S_FORCE = 2'd2;

    function automatic int arb_cnt_width(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating wait counter for the data memory arbiter.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset, clears the count
//   clear     in   return the count to zero this cycle (wins over inc)
//   inc       in   count one more blocked cycle, saturating at MAX_WAIT
//   terminal  out  the count after this cycle's update equals MAX_WAIT
module arb_wait_counter
    import riscv_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = arb_cnt_width(MAX_WAIT)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;

    always_comb begin
        wait_cnt_next = wait_cnt;
        if (clear) begin
            wait_cnt_next = '0;
        end else if (inc && (wait_cnt != CNT_MAX)) begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
        end
    end

    // Terminal looks at the updated value so the FSM can enter its forcing
    // state on the very cycle the last permitted blocked cycle is counted.
    assign terminal = (wait_cnt_next == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt_next;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Data memory arbiter: shares the single-port data memory between the
// pipeline Memory stage (priority master) and a secondary DMA/debug master.
// A DMA request blocked for MAX_WAIT cycles is granted by force for one
// cycle, stalling the pipeline; DMA accesses answer one cycle after accept.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   pipe_req/we/addr/wd, pipe_rd     Memory stage access and load data
//   pipe_stall                       Memory stage must hold and retry
//   dma_req_valid/ready/we/addr/wd   DMA request handshake and fields
//   dma_rsp_valid, dma_rsp_data      one-cycle DMA completion pulse + read data
//   mem_we/addr/wd, mem_rd           Data_Memory pins (combinational read)
module data_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W   = XLEN,
    parameter int DATA_W   = XLEN,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pipe_req,
    input  logic              pipe_we,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wd,
    output logic [DATA_W-1:0] pipe_rd,
    output logic              pipe_stall,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wd,
    output logic              dma_rsp_valid,
    output logic [DATA_W-1:0] dma_rsp_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       dma_gnt;
    logic       dma_blocked;
    logic       cnt_terminal;

    // The pipeline wins unless it is idle or the DMA has starved long enough.
    assign dma_gnt       = dma_req_valid & (~pipe_req | (state == ARB_S_FORCE));
    assign dma_blocked   = dma_req_valid & ~dma_gnt;
    assign dma_req_ready = dma_gnt;
    assign pipe_stall    = pipe_req & dma_gnt;
    assign pipe_rd       = mem_rd;

    // A pipeline store only reaches the memory when the port is actually its.
    always_comb begin
        if (dma_gnt) begin
            mem_we   = dma_we;
            mem_addr = dma_addr;
            mem_wd   = dma_wd;
        end else begin
            mem_we   = pipe_we & pipe_req;
            mem_addr = pipe_addr;
            mem_wd   = pipe_wd;
        end
    end

    // Any cycle that is not a blocked DMA cycle (grant, no request, or a
    // withdrawn request) restarts the starvation count.
    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (~dma_blocked),
        .inc      (dma_blocked),
        .terminal (cnt_terminal)
    );

    // The forcing state always grants a valid request, so it can never be
    // blocked and always falls back to idle; idle cannot force, which leaves
    // the pipeline at least one unstalled cycle after every forced grant.
    always_comb begin
        state_next = ARB_S_IDLE;
        if (dma_blocked) begin
            state_next = cnt_terminal ? ARB_S_FORCE : ARB_S_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read data is captured at accept time, before any later write can
    // disturb the location; writes complete with zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dma_rsp_valid <= 1'b0;
            dma_rsp_data  <= '0;
        end else begin
            dma_rsp_valid <= dma_gnt;
            dma_rsp_data  <= (dma_gnt && !dma_we) ? mem_rd : '0;
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter. A reference model tracks how
// long the current DMA request has waited and what memory must contain, and
// is compared against the DUT every cycle; directed scenarios add literal
// expectations on top.
module tb_data_mem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 4;

    logic              clk;
    logic              rst_n;
    logic              pipe_req;
    logic              pipe_we;
    logic [ADDR_W-1:0] pipe_addr;
    logic [DATA_W-1:0] pipe_wd;
    logic [DATA_W-1:0] pipe_rd;
    logic              pipe_stall;
    logic              dma_req_valid;
    logic              dma_req_ready;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wd;
    logic              dma_rsp_valid;
    logic [DATA_W-1:0] dma_rsp_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] mem_rd;

    int errors = 0;
    int checks = 0;

    data_mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pipe_req      (pipe_req),
        .pipe_we       (pipe_we),
        .pipe_addr     (pipe_addr),
        .pipe_wd       (pipe_wd),
        .pipe_rd       (pipe_rd),
        .pipe_stall    (pipe_stall),
        .dma_req_valid (dma_req_valid),
        .dma_req_ready (dma_req_ready),
        .dma_we        (dma_we),
        .dma_addr      (dma_addr),
        .dma_wd        (dma_wd),
        .dma_rsp_valid (dma_rsp_valid),
        .dma_rsp_data  (dma_rsp_data),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wd        (mem_wd),
        .mem_rd        (mem_rd)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data_Memory stand-in driven by the DUT pins: combinational read,
    // write on the rising edge.
    logic [DATA_W-1:0] envMem [0:255];
    assign mem_rd = envMem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) envMem[mem_addr[9:2]] <= mem_wd;
    end

    // Reference model state.
    logic [DATA_W-1:0] refMem [0:255];
    int                waitedCycles = 0;
    logic              pendValid = 1'b0;
    logic [DATA_W-1:0] pendData = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, actual, expected, $time);
        end
    endtask

    // Compare process: on every falling edge the inputs are stable, so the
    // model decides who owns the port, what must appear on the memory pins,
    // what a load must return, and what the DMA response must be next cycle.
    always @(negedge clk) begin
        logic              expGnt;
        logic              expWe;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expWd;
        if (!rst_n) begin
            waitedCycles = 0;
            pendValid    = 1'b0;
            pendData     = '0;
        end else begin
            checkOutput("m_rsp_valid", {31'd0, dma_rsp_valid}, {31'd0, pendValid});
            if (pendValid) checkOutput("m_rsp_data", dma_rsp_data, pendData);

            expGnt = dma_req_valid && (!pipe_req || waitedCycles >= MAX_WAIT);
            checkOutput("m_ready", {31'd0, dma_req_ready}, {31'd0, expGnt});
            checkOutput("m_stall", {31'd0, pipe_stall}, {31'd0, pipe_req && expGnt});

            if (expGnt) begin
                expWe = dma_we; expAddr = dma_addr; expWd = dma_wd;
            end else begin
                expWe = pipe_req && pipe_we; expAddr = pipe_addr; expWd = pipe_wd;
            end
            checkOutput("m_mem_we", {31'd0, mem_we}, {31'd0, expWe});
            checkOutput("m_mem_addr", mem_addr, expAddr);
            if (expWe) checkOutput("m_mem_wd", mem_wd, expWd);

            if (pipe_req && !expGnt && !pipe_we)
                checkOutput("m_pipe_rd", pipe_rd, refMem[pipe_addr[9:2]]);

            pendValid = expGnt;
            pendData  = (expGnt && !dma_we) ? refMem[dma_addr[9:2]] : '0;

            if (expWe) refMem[expAddr[9:2]] = expWd;

            waitedCycles = (dma_req_valid && !expGnt) ? waitedCycles + 1 : 0;
        end
    end

    // One call = one cycle of input values, applied just after the rising edge.
    task automatic applyStimulus(
        input logic preq, input logic pwe, input logic [31:0] paddr, input logic [31:0] pwd,
        input logic dvalid, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        pipe_req      = preq;
        pipe_we       = pwe;
        pipe_addr     = paddr;
        pipe_wd       = pwd;
        dma_req_valid = dvalid;
        dma_we        = dwe;
        dma_addr      = daddr;
        dma_wd        = dwd;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic accepted;
        logic prevStall;
        int   blockedCnt;
        int   reqIdx;

        for (int i = 0; i < 256; i++) begin
            envMem[i] = '0;
            refMem[i] = '0;
        end
        rst_n = 1'b0;
        pipe_req = 0; pipe_we = 0; pipe_addr = 0; pipe_wd = 0;
        dma_req_valid = 0; dma_we = 0; dma_addr = 0; dma_wd = 0;

        // Reset state
        #7;
        checkOutput("rst_rsp_valid", {31'd0, dma_rsp_valid}, 32'd0);
        checkOutput("rst_rsp_data", dma_rsp_data, 32'd0);
        checkOutput("rst_stall", {31'd0, pipe_stall}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycle();

        // No contention: pipeline store then load
        applyStimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2_mem_we", {31'd0, mem_we}, 32'd1);
        checkOutput("t2_mem_addr", mem_addr, 32'h10);
        checkOutput("t2_stall", {31'd0, pipe_stall}, 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t2_load", pipe_rd, 32'hDEADBEEF);

        // DMA read during a pipeline bubble
        applyStimulus(1'b1, 1'b1, 32'h20, 32'hCAFE0020, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0);
        @(negedge clk);
        checkOutput("t3_ready", {31'd0, dma_req_ready}, 32'd1);
        idleCycle();
        @(negedge clk);
        checkOutput("t3_rsp_valid", {31'd0, dma_rsp_valid}, 32'd1);
        checkOutput("t3_rsp_data", dma_rsp_data, 32'hCAFE0020);

        // Starvation: loads for four cycles, store presented from cycle 5
        accepted = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b1, c >= 5, 32'h50, 32'h5555, !accepted, 1'b1, 32'h40, 32'h1234);
            @(negedge clk);
            checkOutput($sformatf("t4_stall_c%0d", c), {31'd0, pipe_stall}, {31'd0, c == 5});
            if (c == 5) checkOutput("t4_force_addr", mem_addr, 32'h40);
            if (c == 6) checkOutput("t4_store_lands", mem_addr, 32'h50);
            if (dma_req_ready) accepted = 1'b1;
        end
        idleCycle();
        checkOutput("t4_mem40", envMem[32'h40 >> 2], 32'h1234);
        checkOutput("t4_mem50", envMem[32'h50 >> 2], 32'h5555);

        // Back-to-back DMA under full pipeline load
        prevStall  = 1'b0;
        blockedCnt = 0;
        reqIdx     = 0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(1'b1, 1'b0, 32'h50, 32'h0, 1'b1, reqIdx[0] == 1'b0,
                          32'h100 + 32'(reqIdx[3:0]) * 4, 32'hB000 + 32'(reqIdx));
            @(negedge clk);
            if (prevStall && pipe_stall)
                checkOutput("t5_consecutive_stall", 32'd1, 32'd0);
            prevStall = pipe_stall;
            if (dma_req_ready) begin
                checkOutput($sformatf("t5_wait_req%0d", reqIdx), 32'(blockedCnt), 32'(MAX_WAIT));
                blockedCnt = 0;
                reqIdx++;
            end else begin
                blockedCnt++;
            end
        end
        checkOutput("t5_req_count", 32'(reqIdx), 32'd6);

        // Same-address race under a forced grant
        applyStimulus(1'b1, 1'b1, 32'h80, 32'h1111, 1'b0, 1'b0, 32'h0, 32'h0);
        accepted = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b1, c >= 5, 32'h80, 32'h2222, !accepted, 1'b0, 32'h80, 32'h0);
            @(negedge clk);
            if (c == 6) begin
                checkOutput("t6_rsp_valid", {31'd0, dma_rsp_valid}, 32'd1);
                checkOutput("t6_rsp_old", dma_rsp_data, 32'h1111);
            end
            if (dma_req_ready) accepted = 1'b1;
        end
        applyStimulus(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("t6_new_value", pipe_rd, 32'h2222);

        // Reset asserted while a response is being delivered
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h77);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h204, 32'h88);
        #2;
        checkOutput("t1_pre_rsp_valid", {31'd0, dma_rsp_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("t1_rsp_valid", {31'd0, dma_rsp_valid}, 32'd0);
        checkOutput("t1_stall", {31'd0, pipe_stall}, 32'd0);
        checkOutput("t1_mem_we", {31'd0, mem_we}, 32'd0);
        idleCycle();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idleCycle();
        idleCycle();
        checkOutput("t1_mem200", envMem[32'h200 >> 2], 32'h77);
        checkOutput("t1_mem204", envMem[32'h204 >> 2], 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
